// File: rtl/seven_seg_entry_ctrl.sv
// Keypad entry controller for a four-digit seven-segment display.
// It collects up to four hex digits, right-aligned with the newest digit
// in d0. It supports backspace and clear. Enter commits the digits to
// 'value', and the committed entry then blinks on the display until a
// new digit starts another entry.
module seven_seg_entry_ctrl #(
  parameter int BLINK_W = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [1:0]  key_cmd,
  input  logic [3:0]  key_data,
  output logic        key_ready,
  output logic [19:0] disp,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        overflow
);

  typedef enum logic [1:0] {
    EMPTY,
    ENTRY,
    SHOW
  } state_t;

  localparam logic [1:0] CMD_DIGIT = 2'b00;
  localparam logic [1:0] CMD_BKSP  = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b10;
  localparam logic [1:0] CMD_ENTER = 2'b11;
  localparam logic [4:0] BLANK     = 5'b10000;

  state_t              state, state_nxt;
  logic [3:0][3:0]     digits, digits_nxt;   // digits[3] = d3 ... digits[0] = d0
  logic [2:0]          cnt, cnt_nxt;
  logic [BLINK_W-1:0]  blink;
  logic                blink_clr;
  logic [15:0]         value_nxt;
  logic                value_valid_nxt;
  logic                overflow_nxt;
  logic                accept;
  logic                blank_all;

  // The controller is busy only in the cycle that presents a new value.
  assign key_ready = ~value_valid;
  assign accept    = key_valid & key_ready;

  // Next-state logic: decode the accepted keypad event for the current state.
  always_comb begin
    // NOTE: every signal gets a default before the case tree so that no path leaves it unassigned (no latches).
    state_nxt       = state;
    digits_nxt      = digits;
    cnt_nxt         = cnt;
    value_nxt       = value;
    value_valid_nxt = 1'b0;
    overflow_nxt    = 1'b0;
    blink_clr       = 1'b0;

    if (accept) begin
      unique case (state)
        EMPTY: begin
          if (key_cmd == CMD_DIGIT) begin
            digits_nxt = {12'h000, key_data};
            cnt_nxt    = 3'd1;
            state_nxt  = ENTRY;
          end
        end

        ENTRY: begin
          unique case (key_cmd)
            CMD_DIGIT: begin
              if (cnt == 3'd4) begin
                overflow_nxt = 1'b1;   // the digit is dropped and the entry stays as it is
              end else begin
                digits_nxt = {digits[2:0], key_data};
                cnt_nxt    = cnt + 3'd1;
              end
            end
            CMD_BKSP: begin
              digits_nxt = {4'h0, digits[3:1]};
              cnt_nxt    = cnt - 3'd1;
              if (cnt == 3'd1) state_nxt = EMPTY;
            end
            CMD_CLEAR: begin
              digits_nxt = '0;
              cnt_nxt    = 3'd0;
              state_nxt  = EMPTY;
            end
            CMD_ENTER: begin
              value_nxt       = digits;  // unentered positions already hold 0
              value_valid_nxt = 1'b1;
              blink_clr       = 1'b1;    // the committed value is shown first, then blanked
              state_nxt       = SHOW;
            end
            default: ;
          endcase
        end

        SHOW: begin
          if (key_cmd == CMD_DIGIT) begin
            digits_nxt = {12'h000, key_data};
            cnt_nxt    = 3'd1;
            state_nxt  = ENTRY;
          end else if (key_cmd == CMD_CLEAR) begin
            digits_nxt = '0;
            cnt_nxt    = 3'd0;
            state_nxt  = EMPTY;
          end
        end

        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State register. Reset is asynchronous, so an entry is aborted at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= EMPTY;
      digits      <= '0;
      cnt         <= 3'd0;
      value       <= 16'h0000;
      value_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
      state       <= state_nxt;
      digits      <= digits_nxt;
      cnt         <= cnt_nxt;
      value       <= value_nxt;
      value_valid <= value_valid_nxt;
      overflow    <= overflow_nxt;
    end
  end

  // Free-running blink counter. Enter restarts it so SHOW begins in the visible phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           blink <= '0;
    else if (blink_clr) blink <= '0;
    else                blink <= blink + BLINK_W'(1);
  end

  assign blank_all = (state == EMPTY) || ((state == SHOW) && blink[BLINK_W-1]);

  // Display fields: entered digits are right-aligned. Unused fields and the blink-off phase are blank.
  always_comb begin
    disp = {4{BLANK}};
    if (!blank_all) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < cnt) disp[5*k +: 5] = {1'b0, digits[k]};
      end
    end
  end

endmodule

// File: doc/seven_seg_entry_ctrl.md
SEVEN_SEG_ENTRY_CTRL -- requirements
Module: seven_seg_entry_ctrl

Interface
REQ-001 SHALL have parameter BLINK_W, default 23, giving the width of the blink counter; the blink phase is the counter MSB.
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 SHALL have port key_valid  input  1  keypad event present.
REQ-005 SHALL have port key_cmd  input  2  event type: 00 digit, 01 backspace, 10 clear, 11 enter.
REQ-006 SHALL have port key_data  input  4  hex digit value, used only when key_cmd=00.
REQ-007 SHALL have port key_ready  output  1  controller can accept an event this cycle.
REQ-008 SHALL have port disp  output  20  four 5-bit display fields, [19:15] leftmost to [4:0] rightmost; field bit4=1 means blank, else bits[3:0] is a hex digit.
REQ-009 SHALL have port value  output  16  last committed entry, digit 3 in [15:12].
REQ-010 SHALL have port value_valid  output  1  one-cycle pulse when value updates.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse when a digit is dropped.

Function
REQ-012 SHALL accept an event only on a cycle with key_valid=1 and key_ready=1; all effects are visible on the outputs from the following cycle.
REQ-013 SHALL hold key_ready=1 in every cycle except the cycle in which value_valid=1, where key_ready=0.
REQ-014 SHALL keep four 4-bit digit registers d3..d0 and a count cnt (0..4) of entered digits; entry is right-aligned, newest digit in d0.
REQ-015 SHALL implement FSM states EMPTY, ENTRY, SHOW.
REQ-016 EMPTY: every disp field = 5'b10000; digit -> d0=key_data, cnt=1, go ENTRY; backspace, clear, enter -> no change.
REQ-017 ENTRY digit with cnt<4: shift d2..d0 into d3..d1, d0=key_data, cnt+1.
REQ-018 ENTRY digit with cnt=4: digits unchanged, overflow=1 for one cycle, stay ENTRY.
REQ-019 ENTRY backspace: shift d3..d1 into d2..d0, d3=0, cnt-1; if cnt becomes 0, go EMPTY.
REQ-020 ENTRY clear: d3..d0=0, cnt=0, go EMPTY.
REQ-021 ENTRY enter: value={d3,d2,d1,d0} (unentered digits read as 0), value_valid=1 for one cycle, blink counter reset to 0, go SHOW.
REQ-022 ENTRY/SHOW disp: field k (k=0 rightmost) shows {1'b0,dk} when k<cnt, else 5'b10000.
REQ-023 SHOW: when blink phase=1, all fields = 5'b10000; when 0, as REQ-022.
REQ-024 SHOW digit: d3..d1=0, d0=key_data, cnt=1, go ENTRY (new entry, value unchanged).
REQ-025 SHOW clear: digits=0, cnt=0, go EMPTY; backspace and enter in SHOW -> no change.
REQ-026 Blink counter SHALL be free-running BLINK_W bits, wrapping from all-ones to 0.
REQ-027 overflow and value_valid SHALL never be asserted in the same cycle.

Reset
REQ-028 While rst=0: state EMPTY, d3..d0=0, cnt=0, blink counter=0, value=16'h0000, value_valid=0, overflow=0, key_ready=1, disp=20'h84210 (all blank); assertion mid-operation aborts any entry immediately, without waiting for a clock edge.
REQ-029 After rst rises, the first event is accepted on the first clock edge with key_valid=1.

Verification (BLINK_W=4)
REQ-030 Digits 1,2,3 then enter -> disp fields blank,1,2,3; value=16'h0123, value_valid pulses once, key_ready=0 in that cycle only.
REQ-031 Digits A,B,C,D,E -> disp A,B,C,D; overflow pulses exactly once, on the E acceptance.
REQ-032 Digits 5,6 then backspace twice -> disp 5 then all blank; state EMPTY; further backspace gives no change.
REQ-033 In SHOW after value 0x0123 -> disp alternates value/all-blank every 8 cycles; digit 7 -> disp blank,blank,blank,7; value stays 0x0123.
REQ-034 rst=0 asserted mid-entry between clock edges -> disp=20'h84210 and value=0 immediately; key_valid held 1 during reset has no effect.
REQ-035 Enter and backspace in EMPTY, key_valid=0 with key_cmd toggling -> no output change.
